// File: rtl/mem_dcache_fill_pkg.sv
// Shared definitions for the data-cache line refill engine.
//   fill_state_e     : refill FSM state encoding (3 bits)
//   FILL_WAIT_CYCLES : cycles between the dirty-read pulse and the line write.
//                      This must equal the depth of the cache's dirty-victim
//                      capture pipeline.
//   addr_align_bits  : number of low byte-address bits cleared to line-align
//                      an address, derived from the line width in bits.
package mem_dcache_fill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_COLLECT = 3'd2,
    ST_DIRTY   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_FILL    = 3'd5
  } fill_state_e;

  localparam int unsigned FILL_WAIT_CYCLES = 2;

  // A line of 2**log2_line_bits bits spans 2**(log2_line_bits-3) bytes.
  function automatic int unsigned addr_align_bits(input int unsigned log2_line_bits);
    return log2_line_bits - 3;
  endfunction

endpackage

// File: rtl/mem_fill_assembler.sv
// Gathers DRAM beats into one cache line.
//   clk, resetn : clock, synchronous active-low reset (clears counter and line)
//   clear       : restart the beat counter at slot 0
//   beat_we     : write beat_data into the slot selected by the beat counter,
//                 then advance the counter
//   beat_data   : incoming DRAM beat
//   last_beat   : the counter points at the final slot of the line
//   line        : assembled line; slot k occupies [k*DRAMWIDTHBITS +: DRAMWIDTHBITS]
module mem_fill_assembler #(
  parameter int unsigned DRAMWIDTHBITS = 128,
  parameter int unsigned NUMBEATS      = 4,
  parameter int unsigned CNTW          = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              clear,
  input  logic                              beat_we,
  input  logic [DRAMWIDTHBITS-1:0]          beat_data,
  output logic                              last_beat,
  output logic [NUMBEATS*DRAMWIDTHBITS-1:0] line
);

  logic [CNTW-1:0] beat_cnt;

  assign last_beat = (beat_cnt == CNTW'(NUMBEATS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt <= '0;
      line     <= '0;
    end else begin
      if (clear) begin
        beat_cnt <= '0;
      end else if (beat_we) begin
        // Wrap explicitly so a single-beat line (1-bit counter) stays at 0.
        beat_cnt <= last_beat ? '0 : beat_cnt + CNTW'(1);
      end
      if (beat_we) begin
        for (int unsigned i = 0; i < NUMBEATS; i++) begin
          if (beat_cnt == CNTW'(i)) begin
            line[i*DRAMWIDTHBITS +: DRAMWIDTHBITS] <= beat_data;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_dcache_fill.sv
// Data-cache line refill engine. Accepts one miss at a time, issues a single
// DRAM burst read, assembles the returned beats into a line, then drives the
// cache fill port: a one-cycle dirty-read pulse, a fixed wait matching the
// cache's victim-capture pipeline, then a one-cycle line write.
//   clk, resetn        : clock, synchronous active-low reset
//   miss_valid/ready   : miss request handshake; miss_addr is a byte address
//   miss_done          : one-cycle pulse in the line-write cycle
//   dram_rdreq/rdack   : burst read request (held until ack), dram_rdaddr
//   dram_rddata/rdvalid: returned beats
//   fill_addr/fill_data: line-aligned address and assembled line
//   fill_rddirty       : dirty-check pulse to the cache
//   fill_we            : line write strobe to the cache
module mem_dcache_fill
  import mem_dcache_fill_pkg::*;
#(
  parameter int unsigned LOG2CACHELINESIZE = 9,
  parameter int unsigned LOG2DRAMWIDTHBITS = 7,
  parameter int unsigned CACHELINESIZE     = 2**LOG2CACHELINESIZE,
  parameter int unsigned DRAMWIDTHBITS     = 2**LOG2DRAMWIDTHBITS,
  parameter int unsigned NUMBEATS          = CACHELINESIZE / DRAMWIDTHBITS
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     miss_valid,
  input  logic [31:0]              miss_addr,
  output logic                     miss_ready,
  output logic                     miss_done,
  output logic                     dram_rdreq,
  output logic [31:0]              dram_rdaddr,
  input  logic                     dram_rdack,
  input  logic [DRAMWIDTHBITS-1:0] dram_rddata,
  input  logic                     dram_rdvalid,
  output logic [31:0]              fill_addr,
  output logic [CACHELINESIZE-1:0] fill_data,
  output logic                     fill_rddirty,
  output logic                     fill_we
);

  localparam int unsigned BEATCNTW   = (LOG2CACHELINESIZE > LOG2DRAMWIDTHBITS) ?
                                       (LOG2CACHELINESIZE - LOG2DRAMWIDTHBITS) : 1;
  localparam int unsigned ALIGNBITS  = addr_align_bits(LOG2CACHELINESIZE);
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFF << ALIGNBITS;

  fill_state_e state;
  logic [1:0]  wait_cnt;
  logic [31:0] line_addr;
  logic        beat_we;
  logic        clear_cnt;
  logic        last_beat;

  assign clear_cnt = (state == ST_IDLE) && miss_valid;
  // A beat arriving together with the ack is the first beat of the burst.
  assign beat_we   = dram_rdvalid &&
                     ((state == ST_COLLECT) || ((state == ST_REQ) && dram_rdack));

  assign dram_rdaddr = line_addr;
  assign fill_addr   = line_addr;

  mem_fill_assembler #(
    .DRAMWIDTHBITS (DRAMWIDTHBITS),
    .NUMBEATS      (NUMBEATS),
    .CNTW          (BEATCNTW)
  ) u_assembler (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear_cnt),
    .beat_we   (beat_we),
    .beat_data (dram_rddata),
    .last_beat (last_beat),
    .line      (fill_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      miss_ready   <= 1'b1;
      miss_done    <= 1'b0;
      dram_rdreq   <= 1'b0;
      fill_rddirty <= 1'b0;
      fill_we      <= 1'b0;
      wait_cnt     <= '0;
      line_addr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_valid) begin
            line_addr  <= miss_addr & ALIGN_MASK;
            miss_ready <= 1'b0;
            dram_rdreq <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dram_rdack) begin
            dram_rdreq <= 1'b0;
            // Single-beat lines can complete in the ack cycle itself.
            if (beat_we && last_beat) begin
              fill_rddirty <= 1'b1;
              state        <= ST_DIRTY;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (beat_we && last_beat) begin
            fill_rddirty <= 1'b1;
            state        <= ST_DIRTY;
          end
        end
        ST_DIRTY: begin
          fill_rddirty <= 1'b0;
          wait_cnt     <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 2'(FILL_WAIT_CYCLES - 1)) begin
            fill_we   <= 1'b1;
            miss_done <= 1'b1;
            state     <= ST_FILL;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_FILL: begin
          fill_we    <= 1'b0;
          miss_done  <= 1'b0;
          miss_ready <= 1'b1;
          line_addr  <= '0;
          state      <= ST_IDLE;
        end
        default: begin
          miss_ready   <= 1'b1;
          miss_done    <= 1'b0;
          dram_rdreq   <= 1'b0;
          fill_rddirty <= 1'b0;
          fill_we      <= 1'b0;
          line_addr    <= '0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dcache_fill.sv
// Self-checking bench for mem_dcache_fill: a table of miss scenarios driven
// through a shared sequence task, plus hand-written reset and back-to-back runs.
module tb_mem_dcache_fill;

  localparam int CL = 512;
  localparam int DW = 128;
  localparam int NB = 4;

  logic          clk;
  logic          resetn;
  logic          miss_valid;
  logic [31:0]   miss_addr;
  logic          miss_ready;
  logic          miss_done;
  logic          dram_rdreq;
  logic [31:0]   dram_rdaddr;
  logic          dram_rdack;
  logic [DW-1:0] dram_rddata;
  logic          dram_rdvalid;
  logic [31:0]   fill_addr;
  logic [CL-1:0] fill_data;
  logic          fill_rddirty;
  logic          fill_we;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CL-1:0] last_line;

  mem_dcache_fill #(
    .LOG2CACHELINESIZE (9),
    .LOG2DRAMWIDTHBITS (7)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .miss_done    (miss_done),
    .dram_rdreq   (dram_rdreq),
    .dram_rdaddr  (dram_rdaddr),
    .dram_rdack   (dram_rdack),
    .dram_rddata  (dram_rddata),
    .dram_rdvalid (dram_rdvalid),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .fill_rddirty (fill_rddirty),
    .fill_we      (fill_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish within 200000");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_addr;
    int          ack_delay;
    bit          gap;
    bit          ack_beat;
    bit          stray_wait;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_val(input int v, input int k);
    logic [31:0] w;
    w = {4'(4'hA + k), 4'(v), 24'h5A5A00 | 24'(k)};
    return {4{w}};
  endfunction

  // Starts and ends at a negedge; the end point is the IDLE cycle after FILL.
  task automatic run_miss(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input int ack_delay, input bit gap, input bit ack_beat,
                          input bit stray_wait, input bit hold,
                          input logic [31:0] next_addr, input int v);
    logic [CL-1:0] exp_line;
    int req_hi;
    int k;
    for (int i = 0; i < NB; i++) exp_line[i*DW +: DW] = beat_val(v, i);
    check("idle_ready", miss_ready, 1);
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(negedge clk);
    if (!hold) miss_valid = 1'b0;
    check("rdaddr", dram_rdaddr, exp_addr);
    check("filladdr_busy", fill_addr, exp_addr);
    check("ready_busy", miss_ready, 0);
    req_hi = 0;
    for (int i = 0; i < ack_delay; i++) begin
      if (dram_rdreq) req_hi++;
      @(negedge clk);
    end
    if (dram_rdreq) req_hi++;
    dram_rdack = 1'b1;
    k = 0;
    if (ack_beat) begin
      dram_rdvalid = 1'b1;
      dram_rddata  = beat_val(v, 0);
      k = 1;
    end
    @(negedge clk);
    dram_rdack   = 1'b0;
    dram_rdvalid = 1'b0;
    check("rdreq_cycles", req_hi, ack_delay + 1);
    check("rdreq_drop", dram_rdreq, 0);
    while (k < NB) begin
      check("no_early_dirty", fill_rddirty, 0);
      if (gap) @(negedge clk);
      dram_rdvalid = 1'b1;
      dram_rddata  = beat_val(v, k);
      k++;
      @(negedge clk);
      dram_rdvalid = 1'b0;
    end
    check("rddirty", fill_rddirty, 1);
    check("line_dirty", fill_data, exp_line);
    check("we_in_dirty", fill_we, 0);
    if (stray_wait) begin dram_rdvalid = 1'b1; dram_rddata = '1; end
    @(negedge clk);
    dram_rdvalid = 1'b0;
    check("rddirty_pulse", fill_rddirty, 0);
    check("we_wait1", fill_we, 0);
    if (stray_wait) begin dram_rdvalid = 1'b1; dram_rddata = '1; end
    @(negedge clk);
    dram_rdvalid = 1'b0;
    check("we_wait2", fill_we, 0);
    check("line_wait", fill_data, exp_line);
    @(negedge clk);
    check("fill_we", fill_we, 1);
    check("miss_done", miss_done, 1);
    check("fill_addr", fill_addr, exp_addr);
    check("line_fill", fill_data, exp_line);
    if (hold) miss_addr = next_addr;
    @(negedge clk);
    check("we_pulse", fill_we, 0);
    check("done_pulse", miss_done, 0);
    check("ready_back", miss_ready, 1);
    last_line = exp_line;
  endtask

  initial begin
    vecs[0] = '{addr: 32'h0000_1234, exp_addr: 32'h0000_1200, ack_delay: 0, gap: 0, ack_beat: 0, stray_wait: 0};
    vecs[1] = '{addr: 32'h0000_567F, exp_addr: 32'h0000_5640, ack_delay: 4, gap: 1, ack_beat: 0, stray_wait: 0};
    vecs[2] = '{addr: 32'hDEAD_BEEF, exp_addr: 32'hDEAD_BEC0, ack_delay: 2, gap: 0, ack_beat: 1, stray_wait: 1};
    vecs[3] = '{addr: 32'hFFFF_FFC0, exp_addr: 32'hFFFF_FFC0, ack_delay: 1, gap: 1, ack_beat: 1, stray_wait: 0};

    resetn       = 1'b0;
    miss_valid   = 1'b0;
    miss_addr    = '0;
    dram_rdack   = 1'b0;
    dram_rddata  = '0;
    dram_rdvalid = 1'b0;
    last_line    = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    check("rst_ready", miss_ready, 1);
    check("rst_done", miss_done, 0);
    check("rst_rdreq", dram_rdreq, 0);
    check("rst_rddirty", fill_rddirty, 0);
    check("rst_we", fill_we, 0);
    check("rst_rdaddr", dram_rdaddr, 0);
    check("rst_filladdr", fill_addr, 0);
    check("rst_filldata", fill_data, 0);

    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        // Stray beats while idle must leave the held line untouched.
        dram_rdvalid = 1'b1;
        dram_rddata  = '1;
        repeat (2) @(negedge clk);
        dram_rdvalid = 1'b0;
        check("idle_stray_line", fill_data, last_line);
        check("idle_stray_rdreq", dram_rdreq, 0);
        check("idle_stray_ready", miss_ready, 1);
      end
      run_miss(vecs[i].addr, vecs[i].exp_addr, vecs[i].ack_delay, vecs[i].gap,
               vecs[i].ack_beat, vecs[i].stray_wait, 1'b0, 32'h0, i + 1);
    end

    // Reset in the middle of a burst, followed by late beats.
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_2000;
    @(negedge clk);
    miss_valid = 1'b0;
    dram_rdack = 1'b1;
    @(negedge clk);
    dram_rdack = 1'b0;
    for (int j = 0; j < 2; j++) begin
      dram_rdvalid = 1'b1;
      dram_rddata  = beat_val(9, j);
      @(negedge clk);
      dram_rdvalid = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int j = 0; j < 2; j++) begin
      dram_rdvalid = 1'b1;
      dram_rddata  = '1;
      @(negedge clk);
      dram_rdvalid = 1'b0;
    end
    check("mid_rst_ready", miss_ready, 1);
    check("mid_rst_rdreq", dram_rdreq, 0);
    check("mid_rst_rddirty", fill_rddirty, 0);
    check("mid_rst_we", fill_we, 0);
    check("mid_rst_done", miss_done, 0);
    check("mid_rst_rdaddr", dram_rdaddr, 0);
    check("mid_rst_filladdr", fill_addr, 0);
    check("mid_rst_data", fill_data, 0);
    run_miss(32'h0000_4000, 32'h0000_4000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5);

    // Back-to-back: miss_valid held across the first miss.
    run_miss(32'h0000_0100, 32'h0000_0100, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_8000, 6);
    run_miss(32'h0000_8000, 32'h0000_8000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dcache_fill.md
Name: mem_dcache_fill

Overview:
Line-refill engine directly upstream of the data cache fill port. It accepts one miss request at a time and issues a single burst read to DRAM. It gathers DRAMWIDTHBITS-wide beats into one full cache line. It then drives the cache fill port with the required timing: a dirty-read pulse first, so the cache can evict a dirty victim into the write-back buffer, then the line write.

Parameters:
- LOG2CACHELINESIZE, 9, log2 of cache line width in bits (512).
- LOG2DRAMWIDTHBITS, 7, log2 of DRAM beat width in bits (128). Must be ≤ LOG2CACHELINESIZE.
- CACHELINESIZE, 2**LOG2CACHELINESIZE, line width in bits.
- DRAMWIDTHBITS, 2**LOG2DRAMWIDTHBITS, beat width in bits.
- NUMBEATS, CACHELINESIZE/DRAMWIDTHBITS, beats per line (4).

Ports:
- clk  in  1  single clock for the block; it runs on the cache's memory-side clock.
- resetn  in  1  reset, synchronous, active-low.
- miss_valid  in  1  miss request present.
- miss_addr  in  32  byte address of the missing access.
- miss_ready  out  1  high in IDLE; a request is accepted when miss_valid && miss_ready.
- miss_done  out  1  one-cycle pulse when the line has been written into the cache.
- dram_rdreq  out  1  burst read request, held until acknowledged.
- dram_rdaddr  out  32  line-aligned burst address.
- dram_rdack  in  1  DRAM accepted the request.
- dram_rddata  in  DRAMWIDTHBITS  returned beat.
- dram_rdvalid  in  1  dram_rddata is valid this cycle.
- fill_addr  out  32  line-aligned fill address, connects to the cache mem_filladdr.
- fill_data  out  CACHELINESIZE  assembled line, connects to mem_filldata.
- fill_rddirty  out  1  dirty-check pulse, connects to mem_fillrddirty.
- fill_we  out  1  line write strobe, connects to mem_fillwe.

Behaviour:
- Reset: all state is cleared synchronously on clk when resetn=0.
  - FSM goes to IDLE.
  - dram_rdreq, fill_rddirty, fill_we and miss_done are 0.
  - dram_rdaddr, fill_addr and fill_data are 0.
  - Beat counter is 0.
- A reset in the middle of a burst abandons it. Any later dram_rdvalid is ignored until a new request is in COLLECT.
- Address alignment: the captured line address is {miss_addr[31:LOG2CACHELINESIZE-3], zeros}. dram_rdaddr and fill_addr both carry this value from acceptance until the return to IDLE.
- States and transitions:
  - IDLE: miss_ready=1. On miss_valid, capture the aligned address, clear the beat counter and go to REQ.
  - REQ: dram_rdreq=1. On dram_rdack go to COLLECT. A dram_rdvalid in the same cycle as dram_rdack is captured as beat 0.
  - COLLECT: each dram_rdvalid writes dram_rddata into fill_data[k*DRAMWIDTHBITS +: DRAMWIDTHBITS], where k is the beat counter, then k increments. When the beat with k == NUMBEATS-1 is captured, go to DIRTY.
  - DIRTY: fill_rddirty=1 for exactly one cycle, then go to WAIT.
  - WAIT: 2 cycles, counted by a 2-bit counter. This matches the cache's two-stage dirty-victim capture pipeline. Then go to FILL.
  - FILL: fill_we=1 for exactly one cycle, with miss_done=1 in the same cycle. Next state is IDLE.
- Latency:
  - Acceptance to dram_rdreq: 1 cycle.
  - Last beat to fill_rddirty: 1 cycle.
  - fill_rddirty to fill_we: 3 cycles.
- fill_data and fill_addr are stable from DIRTY through FILL.
- dram_rdvalid in any state other than COLLECT (or the REQ cycle with dram_rdack) is ignored and changes no state.
- miss_valid outside IDLE is not accepted (miss_ready=0). The requester holds it.
- Back-to-back misses: after FILL, IDLE accepts a new request on the next cycle. Minimum spacing between two miss_done pulses is 6 + NUMBEATS cycles with zero DRAM latency.
- Beat counter width is max(1, LOG2CACHELINESIZE-LOG2DRAMWIDTHBITS). With NUMBEATS=1, DIRTY is entered after the single beat.

Decomposition:
- A shared package holds:
  - FSM state encoding: IDLE, REQ, COLLECT, DIRTY, WAIT, FILL (3 bits).
  - The address-alignment width constant LOG2CACHELINESIZE-3.
  - The WAIT length constant 2, shared with the cache's dirty pipeline depth.
- One sub-module: mem_fill_assembler. It contains the beat counter plus the line shift/insert register, and exposes beat_we, clear, last_beat and line.
- The FSM stays in the top level.

Test Plan:
- Single miss: miss_addr=0x0000_1234, zero-latency ack, beats 0xA..,0xB..,0xC..,0xD..
  → dram_rdaddr=0x0000_1200.
  → fill_data has beat0 in [127:0] and beat3 in [511:384].
  → fill_rddirty 1 cycle after the last beat, fill_we 3 cycles later, with fill_addr=0x0000_1200.
- Delayed ack and gapped beats: dram_rdack after 5 cycles, dram_rdvalid toggling every other cycle
  → dram_rdreq held 5 cycles.
  → exactly 4 beats captured in order.
  → miss_done occurs once.
- Ack plus first beat in the same cycle: dram_rdack=1 and dram_rdvalid=1 together
  → that beat lands in slot 0.
  → only 3 further beats are needed before DIRTY.
- Stray beats: dram_rdvalid pulses while in IDLE and in WAIT
  → fill_data unchanged, no state change.
- Reset mid-burst: resetn=0 after 2 beats, then 2 more dram_rdvalid
  → all outputs 0, FSM in IDLE, miss_ready=1.
  → a new miss to 0x0000_4000 completes normally.
- Back-to-back: miss_valid held with addresses 0x100, then 0x8000
  → second request accepted on the cycle after the first miss_done.
  → two distinct fill_we pulses with the correct addresses.
